fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/myrv_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/myrv_pkg.sv
// Shared definitions for the instruction fetch front end.
package myrv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // FS_REQ: free to issue, FS_WAIT: one live request, FS_DROP: one stale request
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  // Buffer payload: instruction word in the upper half, its address in the lower.
  typedef struct packed {
    logic [ILEN-1:0] data;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between instruction memory and decode.
// Flush wins over a same-cycle push or pop.
module fetch_fifo
  import myrv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [63:0] push_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [63:0] data_o,
  output logic [1:0]  count_o
);

  logic [63:0] mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        do_push;
  logic        do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (count_q != 2'd0) && !flush_i;

  // Storage, pointers and occupancy; entries are zeroed by reset so the
  // read port shows zero while the buffer is held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Request throttling upstream must keep a full buffer from being written.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && count_q == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one word-aligned request at a time, buffers
// returned words with their addresses, and handles execute redirects,
// discarding responses that belong to a request made before a redirect.
module fetch_unit
  import myrv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  // The buffer is built with two entries; no other depth is supported.
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam logic [1:0] DEPTH_C = FIFO_DEPTH[1:0];

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            req_fire;
  logic            fifo_push;
  logic            fifo_valid;
  logic [63:0]     fifo_data;
  logic [1:0]      fifo_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            unused_redirect_lo;

  // Redirect targets are forced word-aligned, so the low bits never matter.
  assign unused_redirect_lo = ^redirect_pc[1:0];

  // rst gates the request so it reads 0 for the whole time reset is held.
  assign imem_req_valid = !rst && (state_q == FS_REQ) &&
                          (fifo_count < DEPTH_C) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Only a live response is buffered; a redirect in the same cycle kills it.
  assign fifo_push       = (state_q == FS_WAIT) && imem_resp_valid && !redirect_valid;
  assign push_entry.data = imem_resp_data;
  assign push_entry.pc   = req_pc_q;

  fetch_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (inst_ready),
    .flush_i     (redirect_valid),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .count_o     (fifo_count)
  );

  assign head_entry = fetch_entry_t'(fifo_data);
  assign inst_valid = fifo_valid;
  assign inst_data  = head_entry.data;
  assign inst_pc    = head_entry.pc;

  // Fetch sequencing: pc, address of the outstanding request, and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FS_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      case (state_q)
        // A request is still in flight: wait it out unless it returns now.
        FS_WAIT, FS_DROP: state_q <= imem_resp_valid ? FS_REQ : FS_DROP;
        default:          state_q <= FS_REQ;
      endcase
    end else begin
      case (state_q)
        FS_REQ: begin
          if (req_fire) begin
            pc_q     <= pc_q + 32'd4;
            req_pc_q <= pc_q;
            state_q  <= FS_WAIT;
          end
        end
        FS_WAIT, FS_DROP: begin
          if (imem_resp_valid) begin
            state_q <= FS_REQ;
          end
        end
        default: state_q <= FS_REQ;
      endcase
    end
  end

  // A response with nothing outstanding is a memory protocol error.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(state_q == FS_REQ && imem_resp_valid));

endmodule
